// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch/predictor/EXE signal bundle for pc_redirect_unit.
// Counter signals exist only when PC_REDIRECT_STATS_EN is defined.
interface pc_redirect_unit_if;
    logic       stall;
    logic       if_prediction;
    logic [9:0] if_PBT;
    logic [1:0] exe_correction;
    logic [9:0] exe_PBT;
    logic [9:0] exe_CNI;
    logic       exe_is_btype;
    logic [9:0] if_PC;
    logic [9:0] id_PC;
    logic [9:0] exe_PC;
    logic       id_valid;
    logic       exe_valid;
    logic       exe_pred;
    logic       flush;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] bp_branch_count;
    logic [15:0] bp_mispredict_count;
`endif
    modport master (
        output stall, if_prediction, if_PBT, exe_correction, exe_PBT, exe_CNI, exe_is_btype,
        input  if_PC, id_PC, exe_PC, id_valid, exe_valid, exe_pred, flush
`ifdef PC_REDIRECT_STATS_EN
        , input bp_branch_count, bp_mispredict_count
`endif
    );
    modport slave (
        input  stall, if_prediction, if_PBT, exe_correction, exe_PBT, exe_CNI, exe_is_btype,
        output if_PC, id_PC, exe_PC, id_valid, exe_valid, exe_pred, flush
`ifdef PC_REDIRECT_STATS_EN
        , output bp_branch_count, bp_mispredict_count
`endif
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC sequencing with IF/ID/EXE tracking and EXE-stage redirect.
// Optional branch statistics counters enabled by PC_REDIRECT_STATS_EN.
module pc_redirect_unit #(
    parameter logic [9:0] RESET_PC = 10'h000
) (
    input  logic              CLK,
    input  logic              rst,
    pc_redirect_unit_if.slave bus
);
    logic [9:0] if_pc_q, if_pc_d, id_pc_q, exe_pc_q;
    logic       id_valid_q, exe_valid_q, id_pred_q, exe_pred_q;
    logic       redirect;
    // corrections from an empty EXE slot are meaningless, so validity gates them
    assign redirect = exe_valid_q & bus.exe_correction[1];
    assign if_pc_d  = redirect          ? (bus.exe_correction[0] ? bus.exe_PBT : bus.exe_CNI) :
                      bus.stall         ? if_pc_q :
                      bus.if_prediction ? bus.if_PBT : if_pc_q + 10'd1;
    always_ff @(posedge CLK) begin
        if (rst) begin
            if_pc_q     <= RESET_PC;
            id_pc_q     <= '0;
            exe_pc_q    <= '0;
            id_valid_q  <= 1'b0;
            exe_valid_q <= 1'b0;
            id_pred_q   <= 1'b0;
            exe_pred_q  <= 1'b0;
        end else begin
            if_pc_q <= if_pc_d;
            if (redirect) begin
                id_valid_q  <= 1'b0;
                exe_valid_q <= 1'b0;
            end else if (bus.stall) begin
                exe_valid_q <= 1'b0;
            end else begin
                id_pc_q     <= if_pc_q;
                id_pred_q   <= bus.if_prediction;
                id_valid_q  <= 1'b1;
                exe_pc_q    <= id_pc_q;
                exe_pred_q  <= id_pred_q;
                exe_valid_q <= id_valid_q;
            end
        end
    end
    assign bus.if_PC     = if_pc_q;
    assign bus.id_PC     = id_pc_q;
    assign bus.exe_PC    = exe_pc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.exe_valid = exe_valid_q;
    assign bus.exe_pred  = exe_pred_q;
    assign bus.flush     = redirect;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] branch_cnt_q, mispredict_cnt_q;
    logic        branch_inc, mispredict_inc;
    assign branch_inc     = exe_valid_q & bus.exe_is_btype & ~&branch_cnt_q;
    assign mispredict_inc = redirect & bus.exe_is_btype & ~&mispredict_cnt_q;
    always_ff @(posedge CLK) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_q + {15'd0, branch_inc};
            mispredict_cnt_q <= mispredict_cnt_q + {15'd0, mispredict_inc};
        end
    end
    assign bus.bp_branch_count     = branch_cnt_q;
    assign bus.bp_mispredict_count = mispredict_cnt_q;
`else
    logic unused_btype;
    assign unused_btype = bus.exe_is_btype;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed and randomized checks of pc_redirect_unit against a
// stage-array pipeline model; counter checks when PC_REDIRECT_STATS_EN is defined.
module tb_pc_redirect_unit;
    localparam logic [9:0] RST_PC = 10'h010;
    typedef struct packed {
        logic [9:0] pc;
        logic       pred;
        logic       valid;
    } st_t;
    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    st_t  m [3];
    pc_redirect_unit_if bus();
    pc_redirect_unit #(.RESET_PC(RST_PC)) dut (.CLK(CLK), .rst(rst), .bus(bus));
    always #5 CLK = ~CLK;

    // model: slot 0 = IF, 1 = ID, 2 = EXE; one call = one clock edge
    task automatic advance();
        st_t n [3];
        logic redir;
        n = m;
        redir = m[2].valid && bus.exe_correction[1];
        if (rst) begin
            n[0] = '{RST_PC, 1'b0, 1'b0};
            n[1] = '0;
            n[2] = '0;
        end else if (redir) begin
            n[0].pc = bus.exe_correction[0] ? bus.exe_PBT : bus.exe_CNI;
            n[1].valid = 1'b0;
            n[2].valid = 1'b0;
        end else if (bus.stall) begin
            n[2].valid = 1'b0;
        end else begin
            n[2] = m[1];
            n[1] = '{m[0].pc, bus.if_prediction, 1'b1};
            n[0].pc = bus.if_prediction ? bus.if_PBT : m[0].pc + 10'd1;
        end
        @(posedge CLK);
        #1;
        m = n;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.if_prediction = 0; bus.if_PBT = 0;
        bus.exe_correction = 0; bus.exe_PBT = 0; bus.exe_CNI = 0; bus.exe_is_btype = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        advance();
        advance();
        n_tests++; if (bus.if_PC !== RST_PC) begin n_fail++; $display("FAIL reset_if_pc got %h want %h", bus.if_PC, RST_PC); end
        n_tests++; if (bus.id_valid !== 1'b0 || bus.exe_valid !== 1'b0 || bus.exe_pred !== 1'b0) begin n_fail++; $display("FAIL reset_valid got id=%b exe=%b pred=%b want 0", bus.id_valid, bus.exe_valid, bus.exe_pred); end
        rst = 0;
        bus.exe_correction = 2'b11;
        #1;
        n_tests++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        bus.exe_correction = 2'b00;
        advance();
        n_tests++; if (bus.if_PC !== 10'h011 || bus.id_valid !== 1'b1 || bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL release1 got pc=%h id_v=%b exe_v=%b want 011 1 0", bus.if_PC, bus.id_valid, bus.exe_valid); end
        advance();
        n_tests++; if (bus.if_PC !== 10'h012 || bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL release2 got pc=%h exe_v=%b want 012 1", bus.if_PC, bus.exe_valid); end
    endtask

    task automatic test_predict();
        int k = 0;
        while (bus.if_PC !== 10'h020 && k < 40) begin advance(); k++; end
        n_tests++; if (bus.if_PC !== 10'h020) begin n_fail++; $display("FAIL reach_020 got %h want 020", bus.if_PC); end
        bus.if_prediction = 1; bus.if_PBT = 10'h080;
        advance();
        bus.if_prediction = 0;
        n_tests++; if (bus.if_PC !== 10'h080) begin n_fail++; $display("FAIL predict_pc got %h want 080", bus.if_PC); end
        advance();
        n_tests++; if (bus.exe_PC !== 10'h020 || bus.exe_pred !== 1'b1) begin n_fail++; $display("FAIL predict_exe got pc=%h pred=%b want 020 1", bus.exe_PC, bus.exe_pred); end
    endtask

    task automatic test_mispredict();
        bus.exe_correction = 2'b10; bus.exe_CNI = 10'h021;
        #1;
        n_tests++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL mispredict_flush got %b want 1", bus.flush); end
        advance();
        bus.exe_correction = 2'b00;
        n_tests++; if (bus.if_PC !== 10'h021 || bus.id_valid !== 1'b0 || bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL mispredict_next got pc=%h id_v=%b exe_v=%b want 021 0 0", bus.if_PC, bus.id_valid, bus.exe_valid); end
    endtask

    task automatic test_stall_redirect();
        advance();
        advance();
        n_tests++; if (bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL refill_exe_valid got %b want 1", bus.exe_valid); end
        bus.stall = 1; bus.exe_correction = 2'b11; bus.exe_PBT = 10'h100;
        #1;
        n_tests++; if (bus.flush !== 1'b1) begin n_fail++; $display("FAIL stall_redirect_flush got %b want 1", bus.flush); end
        advance();
        bus.stall = 0; bus.exe_correction = 2'b00;
        n_tests++; if (bus.if_PC !== 10'h100 || bus.id_valid !== 1'b0 || bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL stall_redirect got pc=%h id_v=%b exe_v=%b want 100 0 0", bus.if_PC, bus.id_valid, bus.exe_valid); end
    endtask

    task automatic test_wrap_stall();
        advance();
        advance();
        bus.exe_correction = 2'b11; bus.exe_PBT = 10'h3FF;
        advance();
        bus.exe_correction = 2'b00;
        n_tests++; if (bus.if_PC !== 10'h3FF) begin n_fail++; $display("FAIL wrap_setup got %h want 3ff", bus.if_PC); end
        advance();
        n_tests++; if (bus.if_PC !== 10'h000 || bus.id_PC !== 10'h3FF) begin n_fail++; $display("FAIL wrap got pc=%h id=%h want 000 3ff", bus.if_PC, bus.id_PC); end
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            advance();
            n_tests++; if (bus.if_PC !== 10'h000 || bus.id_PC !== 10'h3FF || bus.exe_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d got pc=%h id=%h exe_v=%b want 000 3ff 0", i, bus.if_PC, bus.id_PC, bus.exe_valid); end
        end
        bus.stall = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 40) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.if_prediction = ($urandom_range(0, 3) == 0);
            bus.if_PBT = 10'($urandom);
            bus.exe_correction = 2'($urandom);
            bus.exe_PBT = 10'($urandom);
            bus.exe_CNI = 10'($urandom);
            #1;
            n_tests++; if (bus.flush !== (m[2].valid & bus.exe_correction[1])) begin n_fail++; $display("FAIL rnd_flush cyc %0d got %b want %b", i, bus.flush, m[2].valid & bus.exe_correction[1]); end
            advance();
            n_tests++;
            if (bus.if_PC !== m[0].pc || bus.id_PC !== m[1].pc || bus.exe_PC !== m[2].pc ||
                bus.id_valid !== m[1].valid || bus.exe_valid !== m[2].valid || bus.exe_pred !== m[2].pred) begin
                n_fail++;
                $display("FAIL rnd_state cyc %0d got if=%h id=%h exe=%h idv=%b exv=%b pr=%b want %h %h %h %b %b %b", i,
                         bus.if_PC, bus.id_PC, bus.exe_PC, bus.id_valid, bus.exe_valid, bus.exe_pred,
                         m[0].pc, m[1].pc, m[2].pc, m[1].valid, m[2].valid, m[2].pred);
            end
        end
        rst = 0;
        idle_inputs();
    endtask

`ifdef PC_REDIRECT_STATS_EN
    task automatic wait_exe_valid();
        int k = 0;
        while (bus.exe_valid !== 1'b1 && k < 10) begin advance(); k++; end
        n_tests++; if (bus.exe_valid !== 1'b1) begin n_fail++; $display("FAIL stats_wait exe_valid got %b want 1", bus.exe_valid); end
    endtask

    task automatic test_stats();
        idle_inputs();
        rst = 1;
        advance();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            wait_exe_valid();
            bus.exe_is_btype = 1; bus.exe_correction = (i < 2) ? 2'b10 : 2'b00; bus.exe_CNI = 10'h040;
            advance();
            bus.exe_is_btype = 0; bus.exe_correction = 2'b00;
        end
        n_tests++; if (bus.bp_branch_count !== 16'd5 || bus.bp_mispredict_count !== 16'd2) begin n_fail++; $display("FAIL stats_count got %0d %0d want 5 2", bus.bp_branch_count, bus.bp_mispredict_count); end
        wait_exe_valid();
        force dut.branch_cnt_q = 16'hFFFF;
        force dut.mispredict_cnt_q = 16'hFFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispredict_cnt_q;
        bus.exe_is_btype = 1; bus.exe_correction = 2'b10;
        advance();
        bus.exe_is_btype = 0; bus.exe_correction = 2'b00;
        n_tests++; if (bus.bp_branch_count !== 16'hFFFF || bus.bp_mispredict_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate got %h %h want ffff ffff", bus.bp_branch_count, bus.bp_mispredict_count); end
    endtask
`endif

    initial begin
        m[0] = '0; m[1] = '0; m[2] = '0;
        idle_inputs();
        #1;
        test_reset();
        test_predict();
        test_mispredict();
        test_stall_redirect();
        test_wrap_stall();
        test_random();
`ifdef PC_REDIRECT_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
